// File: rtl/formula_cex_scanner.sv
// formula_cex_scanner
//
// Drives a combinational (or integrator-pipelined) formula checker with every
// assignment of the low CNT_W input bits. The remaining high bits are held at
// the value latched from fixed_bits when the scan starts. The scanner stops at
// the first assignment the formula rejects and reports it as a counterexample.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          begin a scan (only honoured while idle)
//   abort          cancel a running scan, no done pulse
//   fixed_bits     value for the non-enumerated high input bits
//   assign_out     assignment driven to the formula inputs
//   issue_valid    assign_out carries a new assignment this cycle
//   eval_result    formula output, EVAL_LAT cycles behind assign_out
//   busy           scan in progress
//   done           one-cycle pulse when a scan finishes (pass or fail)
//   pass           every assignment held in the last completed scan
//   cex            first falsifying assignment of the last scan
//   checked_count  number of results retired in the current/last scan
module formula_cex_scanner #(
  parameter int N_IN     = 61,
  parameter int CNT_W    = 16,
  parameter int EVAL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [N_IN-1:0]   fixed_bits,
  output logic [N_IN-1:0]   assign_out,
  output logic              issue_valid,
  input  logic              eval_result,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN-1:0]   cex,
  output logic [CNT_W:0]    checked_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Mask selecting the enumerated low bits; the high bits come from fixed_q.
  localparam logic [N_IN-1:0]  LOW_MASK  = N_IN'((64'd1 << CNT_W) - 64'd1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   COUNT_MAX = {1'b1, {CNT_W{1'b0}}};

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic [N_IN-1:0]   fixed_q;

  // Delay line of {valid, tag} that travels alongside the evaluator pipeline.
  logic              dl_valid [EVAL_LAT];
  logic [CNT_W-1:0]  dl_tag   [EVAL_LAT];

  logic              retire_valid;
  logic [CNT_W-1:0]  retire_tag;
  logic              fail_now;
  logic              younger_in_flight;
  logic              final_pass;

  assign busy       = (state != IDLE);
  assign assign_out = (fixed_q & ~LOW_MASK) | N_IN'(cnt);

  // A failing retire kills the issue in the same cycle, so issue_valid has a
  // combinational path from eval_result.
  always_comb begin
    retire_valid      = dl_valid[EVAL_LAT-1];
    retire_tag        = dl_tag[EVAL_LAT-1];
    fail_now          = retire_valid && !eval_result;
    younger_in_flight = 1'b0;
    for (int i = 0; i < EVAL_LAT - 1; i++) begin
      younger_in_flight = younger_in_flight | dl_valid[i];
    end
    issue_valid = (state == RUN) && !fail_now;
    final_pass  = (state == DRAIN) && retire_valid && eval_result && !younger_in_flight;
  end

  // Next-state logic; abort and failure both return straight to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = RUN;
      end
      RUN: begin
        if (abort || fail_now)  next_state = IDLE;
        else if (cnt == CNT_MAX) next_state = DRAIN;
      end
      DRAIN: begin
        if (abort || fail_now || final_pass) next_state = IDLE;
        else if (!retire_valid && !younger_in_flight) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: counter, delay line, result flags. Abort takes priority over a
  // failing retire in the same cycle, so an aborted scan never reports a cex.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      fixed_q       <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      cex           <= '0;
      checked_count <= '0;
      for (int i = 0; i < EVAL_LAT; i++) begin
        dl_valid[i] <= 1'b0;
        dl_tag[i]   <= '0;
      end
    end else begin
      state <= next_state;
      done  <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          fixed_q       <= fixed_bits;
          cnt           <= '0;
          checked_count <= '0;
          pass          <= 1'b0;
          cex           <= '0;
        end
      end else if (abort) begin
        pass <= 1'b0;
        for (int i = 0; i < EVAL_LAT; i++) begin
          dl_valid[i] <= 1'b0;
        end
      end else begin
        if (issue_valid && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
        if (retire_valid && (checked_count != COUNT_MAX)) checked_count <= checked_count + 1'b1;
        if (fail_now) begin
          cex  <= (fixed_q & ~LOW_MASK) | N_IN'(retire_tag);
          pass <= 1'b0;
          done <= 1'b1;
          for (int i = 0; i < EVAL_LAT; i++) begin
            dl_valid[i] <= 1'b0;
          end
        end else begin
          if (final_pass) begin
            pass <= 1'b1;
            done <= 1'b1;
          end
          dl_valid[0] <= issue_valid;
          dl_tag[0]   <= cnt;
          for (int i = 1; i < EVAL_LAT; i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_tag[i]   <= dl_tag[i-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_formula_cex_scanner.sv
// tb_formula_cex_scanner
//
// Exercises formula_cex_scanner with N_IN=8, CNT_W=4, EVAL_LAT=2. The formula
// is modelled as a pipeline of assign_out feeding a rejection mask over the
// low nibble. Expected behaviour of each scan is derived from the first
// rejected index, the latency and an optional abort cycle.
module tb_formula_cex_scanner;

  localparam int N_IN     = 8;
  localparam int CNT_W    = 4;
  localparam int EVAL_LAT = 2;
  localparam int NUM      = 1 << CNT_W;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [N_IN-1:0]  fixed_bits;
  logic [N_IN-1:0]  assign_out;
  logic             issue_valid;
  logic             eval_result;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_IN-1:0]  cex;
  logic [CNT_W:0]   checked_count;

  int total = 0;
  int bad   = 0;

  bit [15:0]       fail_mask = '0;
  bit [N_IN-1:0]   eval_pipe [EVAL_LAT];

  formula_cex_scanner #(
    .N_IN(N_IN), .CNT_W(CNT_W), .EVAL_LAT(EVAL_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .fixed_bits(fixed_bits), .assign_out(assign_out), .issue_valid(issue_valid),
    .eval_result(eval_result), .busy(busy), .done(done), .pass(pass),
    .cex(cex), .checked_count(checked_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Formula model: the assignment travels EVAL_LAT stages, then is rejected
  // if its low nibble is marked in fail_mask.
  always @(posedge clk) begin
    eval_pipe[0] <= assign_out;
    for (int i = 1; i < EVAL_LAT; i++) eval_pipe[i] <= eval_pipe[i-1];
  end
  assign eval_result = !fail_mask[eval_pipe[EVAL_LAT-1][3:0]];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Runs one scan. abort_r = 0 means no abort, otherwise abort is raised in
  // cycle abort_r relative to the start cycle (must be while busy).
  task automatic applyStimulus(input bit [N_IN-1:0] f_bits, input bit [15:0] mask, input int abort_r);
    int  first_fail;
    int  done_r, last_busy, last_issue, last_r;
    bit  aborted;
    int  exp_checked;
    bit  exp_pass;
    bit [N_IN-1:0] exp_cex;

    first_fail = -1;
    for (int i = NUM - 1; i >= 0; i--) if (mask[i]) first_fail = i;
    done_r  = (first_fail >= 0) ? first_fail + EVAL_LAT + 2 : NUM + EVAL_LAT + 1;
    aborted = (abort_r >= 1) && (abort_r <= done_r - 1);
    last_busy  = aborted ? abort_r : done_r - 1;
    last_issue = (first_fail >= 0) ? ((first_fail + EVAL_LAT < NUM) ? first_fail + EVAL_LAT : NUM) : NUM;
    if (aborted && abort_r < last_issue) last_issue = abort_r;
    last_r = aborted ? abort_r + 2 : done_r + 1;

    if (aborted) begin
      exp_checked = (abort_r - 1 - EVAL_LAT > 0) ? abort_r - 1 - EVAL_LAT : 0;
      exp_pass    = 1'b0;
      exp_cex     = '0;
    end else if (first_fail >= 0) begin
      exp_checked = first_fail + 1;
      exp_pass    = 1'b0;
      exp_cex     = {f_bits[7:4], 4'(first_fail)};
    end else begin
      exp_checked = NUM;
      exp_pass    = 1'b1;
      exp_cex     = '0;
    end

    fail_mask = mask;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; fixed_bits = f_bits;
    @(negedge clk);
    checkOutput("busy@r0", 64'(busy), 64'd0);
    for (int r = 1; r <= last_r; r++) begin
      @(posedge clk); #1;
      start      = (r <= last_busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort      = aborted && (r == abort_r);
      fixed_bits = N_IN'($urandom);
      @(negedge clk);
      checkOutput($sformatf("busy@r%0d", r), 64'(busy), 64'(r <= last_busy));
      checkOutput($sformatf("issue@r%0d", r), 64'(issue_valid), 64'(r <= last_issue));
      checkOutput($sformatf("done@r%0d", r), 64'(done), 64'(!aborted && r == done_r));
      if (r <= last_issue)
        checkOutput($sformatf("assign@r%0d", r), 64'(assign_out), 64'({f_bits[7:4], 4'(r - 1)}));
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checkOutput("pass", 64'(pass), 64'(exp_pass));
    checkOutput("cex", 64'(cex), 64'(exp_cex));
    checkOutput("checked_count", 64'(checked_count), 64'(exp_checked));
    checkOutput("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_issue"}, 64'(issue_valid), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_pass"}, 64'(pass), 64'd0);
    checkOutput({tag, "_cex"}, 64'(cex), 64'd0);
    checkOutput({tag, "_count"}, 64'(checked_count), 64'd0);
    checkOutput({tag, "_assign"}, 64'(assign_out), 64'd0);
  endtask

  // Reset asserted during DRAIN together with start: reset must win.
  task automatic resetInDrain(input bit [N_IN-1:0] f_bits);
    fail_mask = '0;
    @(posedge clk); #1;
    start = 1'b1; fixed_bits = f_bits;
    for (int r = 1; r <= NUM + 1; r++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    checkOutput("drain_busy", 64'(busy), 64'd1);
    checkOutput("drain_issue", 64'(issue_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkResetValues("rst_drain");
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("post_rst_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    bit [N_IN-1:0] f;
    bit [15:0]     m;
    int            kind;
    int            ab;
    int            ff;
    int            dr;

    rst = 1'b1; start = 1'b0; abort = 1'b0; fixed_bits = '0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);

    applyStimulus(8'h35, 16'h0200, 0);
    applyStimulus(8'hA7, 16'h0000, 0);
    applyStimulus(8'hFF, 16'h0001, 0);
    applyStimulus(8'h5C, 16'h0000, 5);
    applyStimulus(8'h5C, 16'h0000, 0);
    applyStimulus(8'h91, 16'h8000, 0);
    resetInDrain(8'hC3);

    for (int n = 0; n < 24; n++) begin
      f    = N_IN'($urandom);
      kind = $urandom_range(0, 3);
      case (kind)
        0:       m = '0;
        1:       m = 16'(1) << $urandom_range(0, NUM - 1);
        default: m = 16'($urandom);
      endcase
      ab = 0;
      if ($urandom_range(0, 3) == 0) begin
        ff = -1;
        for (int i = NUM - 1; i >= 0; i--) if (m[i]) ff = i;
        dr = (ff >= 0) ? ff + EVAL_LAT + 2 : NUM + EVAL_LAT + 1;
        ab = $urandom_range(1, dr - 1);
      end
      applyStimulus(f, m, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
